counter_100_dw: RTL and testbench

COUNTER_100_DW -- requirements
Module: counter_100_dw

---
 rtl/counter_100_dw.sv | 48 ++++
 tb/tb_counter_100_dw.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/counter_100_dw.sv
// counter_100_dw: free-running modulo-CNT_MAX counter.
//
// Parameters:
//   CNT_MAX       counter modulus, legal range 2..128; the count runs 0..CNT_MAX-1.
// Ports:
//   clk           sole clock; the count advances on each rising edge
//   reset_n       asynchronous reset, ACTIVE-HIGH despite its name; forces the count to 0
//   o_cnt         registered count, a continuous copy of the count register
//   o_always_cnt  the same count, driven through a combinational always block
module counter_100_dw #(
    parameter int unsigned CNT_MAX = 100
) (
    input  logic       clk,
    input  logic       reset_n,
    output logic [6:0] o_cnt,
    output logic [6:0] o_always_cnt
);

    localparam logic [6:0] CNT_LAST = 7'(CNT_MAX - 1);

    logic [6:0] r_cnt;
    logic [6:0] w_cnt_next;

    // Wrap is detected on the last legal value.
    // CNT_MAX itself is never loaded.
    always_comb begin
        w_cnt_next = r_cnt + 7'd1;
        if (r_cnt == CNT_LAST) begin
            w_cnt_next = 7'd0;
        end
    end

    // reset_n is active-high; the asynchronous clear wins over any coincident edge.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            r_cnt <= 7'd0;
        end else begin
            r_cnt <= w_cnt_next;
        end
    end

    assign o_cnt = r_cnt;

    always_comb begin
        o_always_cnt = r_cnt;
    end

endmodule

// File: tb/tb_counter_100_dw.sv
// tb_counter_100_dw: self-checking bench for counter_100_dw.
// Two instances (CNT_MAX = 100 and CNT_MAX = 10) share the clock and reset.
// The reference is the number of rising edges since reset release, taken modulo the modulus.
module tb_counter_100_dw;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [6:0] cnt100;
    logic [6:0] alw100;
    logic [6:0] cnt10;
    logic [6:0] alw10;

    int  total = 0;
    int  bad = 0;
    int  edges = 0;
    bit  chk_en = 1'b0;

    counter_100_dw #(.CNT_MAX(100)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .o_cnt        (cnt100),
        .o_always_cnt (alw100)
    );

    counter_100_dw #(.CNT_MAX(10)) dut10 (
        .clk          (clk),
        .reset_n      (reset_n),
        .o_cnt        (cnt10),
        .o_always_cnt (alw10)
    );

    always #5 clk = ~clk;

    // Reference: edges counted while out of reset.
    always @(posedge clk) begin
        if (!reset_n) begin
            edges = edges + 1;
        end
    end

    task automatic check(input string name, input logic [6:0] got, input logic [6:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Every-cycle comparison against the reference, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("cnt100", cnt100, 7'(edges % 100));
            check("alw100", alw100, 7'(edges % 100));
            check("cnt10",  cnt10,  7'(edges % 10));
            check("alw10",  alw10,  7'(edges % 10));
        end
    end

    // Assert reset between edges; outputs must clear before the next edge.
    task automatic assert_reset_mid();
        reset_n = 1'b1;
        edges = 0;
        #1;
        check("async_clr_cnt100", cnt100, 7'd0);
        check("async_clr_alw100", alw100, 7'd0);
        check("async_clr_cnt10",  cnt10,  7'd0);
        check("async_clr_alw10",  alw10,  7'd0);
    endtask

    // Hold reset for n edges, then release at posedge+2.
    task automatic hold_and_release(input int n);
        repeat (n) @(posedge clk);
        #2;
        reset_n = 1'b0;
    endtask

    initial begin
        // First reset; outputs before this are unspecified.
        #2;
        reset_n = 1'b1;
        edges = 0;
        #1;
        chk_en = 1'b1;
        check("first_reset", cnt100, 7'd0);

        // Hold reset for 10 edges: outputs stay 0.
        repeat (10) @(posedge clk);
        #1;
        check("hold10_cnt100", cnt100, 7'd0);
        check("hold10_cnt10",  cnt10,  7'd0);
        #1;
        reset_n = 1'b0;

        // First edge after release gives 1.
        @(posedge clk);
        #1;
        check("first_edge_100", cnt100, 7'd1);
        check("first_edge_10",  cnt10,  7'd1);

        // 99 edges after release -> 99 / 9; one more -> 0 / 0.
        repeat (98) @(posedge clk);
        #1;
        check("edge99_100", cnt100, 7'd99);
        check("edge99_10",  cnt10,  7'd9);
        @(posedge clk);
        #1;
        check("wrap_100", cnt100, 7'd0);
        check("wrap_10",  cnt10,  7'd0);

        // 250 edges after release -> 50 / 0.
        repeat (150) @(posedge clk);
        #1;
        check("run250_100", cnt100, 7'd50);
        check("run250_10",  cnt10,  7'd0);

        // Reset mid-count at 57.
        repeat (7) @(posedge clk);
        #1;
        check("at57", cnt100, 7'd57);
        check("at57_10", cnt10, 7'd7);
        #1;
        assert_reset_mid();
        hold_and_release(2);
        repeat (3) @(posedge clk);
        #1;
        check("restart3", cnt100, 7'd3);

        // Reset coinciding with a rising edge wins over the increment.
        repeat (20) @(posedge clk);
        reset_n = 1'b1;
        edges = 0;
        #1;
        check("edge_reset_100", cnt100, 7'd0);
        check("edge_reset_10",  cnt10,  7'd0);
        hold_and_release(1);

        // Randomized run lengths and reset pulses.
        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(260, 1)) @(posedge clk);
            #2;
            if ($urandom_range(1, 0) == 1) begin
                assert_reset_mid();
            end else begin
                @(posedge clk);
                reset_n = 1'b1;
                edges = 0;
            end
            hold_and_release($urandom_range(12, 1));
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
